// File: rtl/ram8_access_port_if.sv
// Request/response bus for the RAM8 access port: single-beat writes, 1-8 beat wrapping reads.
interface ram8_access_port_if #(
  parameter int WIDTH = 16
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [2:0]       req_addr;
  logic [2:0]       req_len;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_last;
  logic             rsp_write;

  modport master (
    output req_valid, req_we, req_addr, req_len, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_write
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_len, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_last, rsp_write
  );
endinterface

// File: rtl/ram8_access_port.sv
// 8 x WIDTH register file behind a valid/ready port; writes are acked with one beat,
// reads return a burst that wraps within the 8 words.
module ram8_word #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= INIT_VALUE;
    else if (we) q <= d;
  end
endmodule

module ram8_access_port #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  ram8_access_port_if.slave  bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WACK   = 2'd1;
  localparam logic [1:0] RBURST = 2'd2;

  logic [1:0]            state;
  logic [2:0]            cur_addr;
  logic [2:0]            count;
  logic [2:0]            next_addr;
  logic                  rsp_valid_q;
  logic                  rsp_last_q;
  logic                  rsp_write_q;
  logic [WIDTH-1:0]      rsp_rdata_q;
  logic                  accept;
  logic [7:0]            word_we;
  logic [7:0][WIDTH-1:0] words;

  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_last  = rsp_last_q;
  assign bus.rsp_write = rsp_write_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  assign accept    = bus.req_valid & bus.req_ready;
  assign next_addr = cur_addr + 3'd1;

  // Load-enable decode: storage only changes on an accepted write, which happens in IDLE,
  // so a burst in flight always sees a stable snapshot.
  for (genvar g = 0; g < 8; g++) begin : g_word
    assign word_we[g] = accept & bus.req_we & (bus.req_addr == 3'(g));
    ram8_word #(.WIDTH(WIDTH), .INIT_VALUE(INIT_VALUE)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (word_we[g]),
      .d     (bus.req_wdata),
      .q     (words[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cur_addr    <= '0;
      count       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= INIT_VALUE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_valid_q <= 1'b1;
            if (bus.req_we) begin
              state       <= WACK;
              rsp_write_q <= 1'b1;
              rsp_last_q  <= 1'b1;
              rsp_rdata_q <= INIT_VALUE;
            end else begin
              state       <= RBURST;
              cur_addr    <= bus.req_addr;
              count       <= bus.req_len;
              rsp_write_q <= 1'b0;
              rsp_last_q  <= (bus.req_len == 3'd0);
              rsp_rdata_q <= words[bus.req_addr];
            end
          end
        end
        WACK: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_last_q  <= 1'b0;
          end
        end
        RBURST: begin
          if (bus.rsp_ready) begin
            if (count != 3'd0) begin
              // Next beat loaded on the handshake edge so beats run back-to-back.
              cur_addr    <= next_addr;
              count       <= count - 3'd1;
              rsp_rdata_q <= words[next_addr];
              rsp_last_q  <= (count == 3'd1);
            end else begin
              state       <= IDLE;
              rsp_valid_q <= 1'b0;
              rsp_last_q  <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ram8_access_port.md
Name: ram8_access_port

Overview:
- 8-word x 16-bit register-file memory behind a valid/ready request/response port.
- Write requests are single-beat. Read requests are bursts of 1–8 beats, with the address wrapping within the 8 words.
- Sits between the CPU/bus sequencer and the RAM8 storage. It is the responding end of the address-select/load interface: it performs load-enable decode and read-select internally and returns data under handshake.
- One request outstanding at a time.

Parameters:
- WIDTH, 16, data word width in bits.
- INIT_VALUE, 16'h0000, value loaded into every storage word and into rsp_rdata on reset.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  port can accept a request.
- req_we  input  1  1 = write, 0 = read burst.
- req_addr  input  3  word address; for reads, the first beat address.
- req_len  input  3  read burst length minus 1 (0 = 1 beat, 7 = 8 beats); ignored for writes.
- req_wdata  input  WIDTH  write data.
- rsp_valid  output  1  response beat present.
- rsp_ready  input  1  consumer accepts the beat.
- rsp_rdata  output  WIDTH  read data; INIT_VALUE on write acks.
- rsp_last  output  1  final beat of the response.
- rsp_write  output  1  beat is a write acknowledge.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE; all 8 words = INIT_VALUE.
  - req_ready = 1, rsp_valid = 0, rsp_last = 0, rsp_write = 0, rsp_rdata = INIT_VALUE.
  - Internal addr/count = 0.
  - Reset mid-burst or mid-ack aborts the transaction; no beat is issued after rst_n deasserts.
- States: IDLE, WACK, RBURST.
- req_ready = 1 only in IDLE. Accept = req_valid & req_ready at a rising edge.
- IDLE, accept with req_we=1:
  - mem[req_addr] <= req_wdata on that edge.
  - Go to WACK; rsp_valid=1, rsp_write=1, rsp_last=1, rsp_rdata=INIT_VALUE from the next cycle.
- IDLE, accept with req_we=0:
  - Latch cur_addr=req_addr and count=req_len.
  - Register rsp_rdata <= mem[req_addr]; go to RBURST.
  - rsp_valid=1, rsp_write=0, rsp_last=(req_len==0) from the next cycle.
  - Read latency: 1 cycle from accept to first beat.
- WACK:
  - Hold all rsp outputs stable while rsp_ready=0.
  - On rsp_ready: rsp_valid, rsp_write and rsp_last <= 0; go to IDLE.
- RBURST:
  - rsp outputs are stable while rsp_ready=0.
  - On beat handshake with count!=0: cur_addr <= cur_addr+1 mod 8 (7 wraps to 0), count <= count-1, rsp_rdata <= mem[cur_addr+1 mod 8], rsp_last <= (count==1). Beats are back-to-back, with no bubble when rsp_ready stays high.
  - On handshake with count==0 (rsp_last=1): rsp_valid and rsp_last <= 0; go to IDLE.
- Inter-transaction gap: req_ready rises the cycle after the final handshake, so there is at least one idle cycle between transactions.
- Data stability: storage is written only from IDLE. Read data within a burst is a consistent snapshot, with each beat's value sampled at its register load.
- Requests presented while req_ready=0 are not accepted; the requester must hold them.
- rsp_rdata holds its last value after a read completes, until the next load.
- Width rules: address arithmetic is 3-bit modulo 8. count is 3-bit and never underflows.

Test Plan:
- Reset then idle: rst_n low 3 cycles -> req_ready=1, rsp_valid=0, rsp_rdata=0; a 1-beat read of addr 5 returns 16'h0000 with rsp_last=1.
- Write/readback: write addr 3 = 16'hBEEF with rsp_ready=1 -> ack beat with rsp_write=1, rsp_last=1 one cycle after accept; read addr 3, len 0 -> rsp_rdata=16'hBEEF, rsp_last=1, latency 1 cycle.
- Wrap burst: fill words 0..7 with 16'h1000+i; read addr 6, len 3 -> beats 16'h1006, 16'h1007, 16'h1000, 16'h1001 on consecutive cycles, rsp_last only on the 4th, then req_ready=1 the following cycle.
- Backpressure: 8-beat read from addr 0 with rsp_ready toggling 1,0,0,1,... -> rsp_rdata/rsp_last are stable while stalled; exactly 8 beats in order 0..7; no req_ready during the burst.
- Blocked request: assert write addr 1 = 16'h5555 during a burst -> it is not accepted until the cycle after the last beat; mem[1] is unchanged until then, and the burst data is unaffected.
- Reset mid-burst: assert rst_n low on beat 2 of a 4-beat read -> rsp_valid=0 immediately (async), all words read 16'h0000 afterward, and the next request is accepted normally.
